decrypt_master: RTL and testbench

- Per-pixel stream decryptor for the batch image cipher.
- Accepts one packed 24-bit RGB ciphertext pixel per clock and returns the plaintext pixel one clock later.
- A 24-bit LFSR keystream, combined with a static key, undoes the encryptor's per-channel XOR and rotate.
- Sits between the pixel source (file/DMA reader) and the image writer; the keystream restarts at each image boundary so a batch of images decrypts back-to-back.

---
 rtl/decy_pkg.sv | 30 +++
 rtl/decy_keystream.sv | 59 +++++
 rtl/decrypt_master.sv | 50 +++++
 tb/tb_decrypt_master.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/decy_pkg.sv
// Shared constants and channel rotate helpers for the per-pixel stream decryptor.
package decy_pkg;

   localparam int PIX_W = 24;
   localparam int CH_W  = 8;
   localparam int ROT_W = 3;
   localparam int N_CH  = 3;

   localparam logic [PIX_W-1:0] SEED_DEFAULT = 24'hACE1B5;
   localparam logic [PIX_W-1:0] KEY_DEFAULT  = 24'h5A3C96;

   // Feedback taps of x^24+x^23+x^22+x^17+1 (bit indices into the LFSR state)
   localparam int TAP_A = 23;
   localparam int TAP_B = 22;
   localparam int TAP_C = 21;
   localparam int TAP_D = 16;

   function automatic logic [CH_W-1:0] rotr8(input logic [CH_W-1:0] v, input logic [ROT_W-1:0] r);
      logic [2*CH_W-1:0] w_dbl;
      w_dbl = {v, v} >> r;
      return w_dbl[CH_W-1:0];
   endfunction

   function automatic logic [CH_W-1:0] rotl8(input logic [CH_W-1:0] v, input logic [ROT_W-1:0] r);
      logic [2*CH_W-1:0] w_dbl;
      w_dbl = {v, v} << r;
      return w_dbl[2*CH_W-1:CH_W];
   endfunction

endpackage

// File: rtl/decy_keystream.sv
// LFSR keystream generator with per-image restart; emits the XOR key and the
// three per-channel rotation amounts for the pixel being sampled this cycle.
module decy_keystream
   import decy_pkg::*;
#(
   parameter logic [PIX_W-1:0] SEED   = SEED_DEFAULT,
   parameter logic [PIX_W-1:0] KEY    = KEY_DEFAULT,
   parameter int unsigned      PIXELS = 1048576
) (
   input  logic             clk,
   input  logic             rst,
   output logic [PIX_W-1:0] o_k,
   output logic [ROT_W-1:0] o_rot_r,
   output logic [ROT_W-1:0] o_rot_g,
   output logic [ROT_W-1:0] o_rot_b
);

   localparam int CNT_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);
   // An all-zero seed would lock the LFSR, so it is replaced by 1
   localparam logic [PIX_W-1:0] SEED_EFF = (SEED == 24'h000000) ? 24'h000001 : SEED;

   logic [PIX_W-1:0] r_lfsr;
   logic [CNT_W-1:0] r_pix_cnt;
   logic [PIX_W-1:0] w_lfsr_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_fb;

   assign w_fb = r_lfsr[TAP_A] ^ r_lfsr[TAP_B] ^ r_lfsr[TAP_C] ^ r_lfsr[TAP_D];

   // Next keystream state: shift, or reload SEED on the last pixel of an image
   always_comb begin
      w_lfsr_next = {r_lfsr[PIX_W-2:0], w_fb};
      w_cnt_next  = r_pix_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (r_pix_cnt == LAST_PIX) begin
         w_lfsr_next = SEED_EFF;
         w_cnt_next  = {CNT_W{1'b0}};
      end else begin
         w_lfsr_next = {r_lfsr[PIX_W-2:0], w_fb};
      end
   end

   // Keystream state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lfsr    <= SEED_EFF;
         r_pix_cnt <= {CNT_W{1'b0}};
      end else begin
         r_lfsr    <= w_lfsr_next;
         r_pix_cnt <= w_cnt_next;
      end
   end

   assign o_k     = r_lfsr ^ KEY;
   assign o_rot_r = r_lfsr[2:0];
   assign o_rot_g = r_lfsr[5:3];
   assign o_rot_b = r_lfsr[8:6];

endmodule

// File: rtl/decrypt_master.sv
// Per-pixel RGB stream decryptor: one ciphertext pixel in per clock,
// plaintext pixel out one clock later.
module decrypt_master
   import decy_pkg::*;
#(
   parameter logic [PIX_W-1:0] SEED   = SEED_DEFAULT,
   parameter logic [PIX_W-1:0] KEY    = KEY_DEFAULT,
   parameter int unsigned      PIXELS = 1048576
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] i,
   output logic [PIX_W-1:0] o
);

   logic [PIX_W-1:0] w_k;
   logic [ROT_W-1:0] w_rot [N_CH];
   logic [PIX_W-1:0] w_plain;
   logic [PIX_W-1:0] r_o;

   decy_keystream #(
      .SEED   (SEED),
      .KEY    (KEY),
      .PIXELS (PIXELS)
   ) u_keystream (
      .clk     (clk),
      .rst     (rst),
      .o_k     (w_k),
      .o_rot_r (w_rot[2]),
      .o_rot_g (w_rot[1]),
      .o_rot_b (w_rot[0])
   );

   // Channel slices: index 0 is B (bits 7:0), 1 is G, 2 is R
   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      assign w_plain[ch*CH_W +: CH_W] = rotr8(i[ch*CH_W +: CH_W], w_rot[ch]) ^ w_k[ch*CH_W +: CH_W];
   end

   // Plaintext output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_o <= 24'h000000;
      end else begin
         r_o <= w_plain;
      end
   end

   assign o = r_o;

endmodule

// File: tb/tb_decrypt_master.sv
// Self-checking bench for decrypt_master: directed vectors, random round trip
// through a reference encryptor, image wrap with PIXELS=4, and mid-image reset.
module tb_decrypt_master;
   import decy_pkg::*;

   localparam logic [23:0] T_SEED = 24'hACE1B5;
   localparam logic [23:0] T_KEY  = 24'h5A3C96;
   localparam int          N_RT   = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] i   = 24'h000000;
   logic [23:0] o;
   logic [23:0] o4;

   int n_cmp = 0;
   int n_mis = 0;

   decrypt_master dut (
      .clk (clk),
      .rst (rst),
      .i   (i),
      .o   (o)
   );

   decrypt_master #(.PIXELS(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .i   (i),
      .o   (o4)
   );

   always #5 clk = ~clk;

   // Reference LFSR step: feedback is the parity of the tapped bits 23,22,21,16
   function automatic logic [23:0] ref_step(input logic [23:0] s);
      return {s[22:0], ^(s & 24'hE10000)};
   endfunction

   // Reference encryptor: c_ch = rotl8(p_ch ^ k_ch, r_ch)
   function automatic logic [23:0] ref_encrypt(input logic [23:0] p, input logic [23:0] s);
      logic [23:0] k;
      k = s ^ T_KEY;
      return {rotl8(p[23:16] ^ k[23:16], s[2:0]),
              rotl8(p[15:8]  ^ k[15:8],  s[5:3]),
              rotl8(p[7:0]   ^ k[7:0],   s[8:6])};
   endfunction

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulse reset just after an edge; the next edge samples pixel 0
   task automatic do_reset;
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      logic [23:0] st;
      logic [23:0] plain [N_RT];
      logic [23:0] st4 [4];
      logic [23:0] exp4;

      // Reset held with toggling input
      for (int n = 0; n < 4; n++) begin
         i = 24'($urandom);
         tick();
         check("reset_o", o, 24'h000000);
         check("reset_o4", o4, 24'h000000);
      end
      rst = 1'b1;

      // Pixel 0 keystream
      i = 24'h000000;
      tick();
      check("pix0_key", o, 24'hF6DD23);

      // Pixel 0 inversion, pixel 1 keystream
      do_reset();
      i = 24'hDE77C8;
      tick();
      check("pix0_inv", o, 24'h000000);
      i = 24'h000000;
      tick();
      check("pix1_key", o, 24'h03FFFC);

      // Random round trip, one pixel per clock
      do_reset();
      for (int n = 0; n < N_RT; n++) plain[n] = 24'($urandom);
      st = T_SEED;
      i = ref_encrypt(plain[0], st);
      for (int n = 0; n < N_RT; n++) begin
         tick();
         check("round_trip", o, plain[n]);
         if (n + 1 < N_RT) begin
            st = ref_step(st);
            i = ref_encrypt(plain[n + 1], st);
         end else begin
            i = 24'h000000;
         end
      end

      // Image wrap with PIXELS=4
      st4[0] = T_SEED;
      for (int n = 1; n < 4; n++) st4[n] = ref_step(st4[n - 1]);
      do_reset();
      i = 24'h000000;
      for (int n = 0; n < 10; n++) begin
         tick();
         exp4 = st4[n % 4] ^ T_KEY;
         if ((n % 4) == 0)      check("wrap_pix0", o4, 24'hF6DD23);
         else if ((n % 4) == 1) check("wrap_pix1", o4, 24'h03FFFC);
         else                   check("wrap_model", o4, exp4);
      end

      // Mid-image reset at pixel 2
      do_reset();
      i = 24'h000000;
      tick();
      check("mid_pix0", o, 24'hF6DD23);
      tick();
      check("mid_pix1", o, 24'h03FFFC);
      #2;
      rst = 1'b0;
      #1;
      check("mid_async_o", o, 24'h000000);
      check("mid_async_o4", o4, 24'h000000);
      #4;
      rst = 1'b1;
      tick();
      check("mid_restart", o, 24'hF6DD23);
      check("mid_restart4", o4, 24'hF6DD23);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
